// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUO      = 32'h8000_0000;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first
// restoring divide, chosen by div_mode.
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic            div_mode,
  input  logic [63:1]     acc_in,
  input  logic            mul_bit,
  input  logic [XLEN-1:0] mcand,
  input  logic [32:0]     rem_in,
  input  logic            div_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [63:0]     acc_out,
  output logic [32:0]     rem_out,
  output logic            q_bit
);

  logic [32:0] sum;
  logic [33:0] trial;

  always_comb begin
    sum     = {1'b0, acc_in[63:32]} + {1'b0, (mul_bit && !div_mode) ? mcand : '0};
    // bit 0 of the accumulator shifts out; the product settles after 32 steps
    acc_out = {sum, acc_in[31:1]};
    // remainder stays below the divisor, so bit 33 of the trial is a clean sign
    trial   = {rem_in, div_bit} - {2'b00, divisor};
    q_bit   = div_mode && !trial[33];
    rem_out = q_bit ? trial[32:0] : {rem_in[31:0], div_bit};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, operand/sign registers,
// iteration counter and sign fix-up of the registered result.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // state  | meaning
  // IDLE   | waiting for start
  // PREP   | record signs, take magnitudes, detect div-by-zero / overflow
  // RUN    | 32 iterations, one per cycle
  // FIX    | sign correction and result select
  // DONE   | result valid, done pulse, may accept a back-to-back start

  state_t            state, state_next;
  logic [2:0]        op;
  logic [XLEN-1:0]   opa, opb;
  logic              s1, s2;
  logic [63:0]       acc, acc_step, prod;
  logic [32:0]       rem, rem_step;
  logic [XLEN-1:0]   quo, quo_fix, rem_fix;
  logic [4:0]        cnt;
  logic              q_bit;
  logic              sgn1, sgn2, div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_val, fix_val;

  muldiv_step u_step (
    .div_mode (op_is_div(op)),
    .acc_in   (acc[63:1]),
    .mul_bit  (opb[cnt]),
    .mcand    (opa),
    .rem_in   (rem),
    .div_bit  (opa[~cnt]),
    .divisor  (opb),
    .acc_out  (acc_step),
    .rem_out  (rem_step),
    .q_bit    (q_bit)
  );

  always_comb begin
    sgn1     = opa[31] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    sgn2     = opb[31] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
    div_zero = op_is_div(op) && (opb == '0);
    div_ovf  = (op == OP_DIV || op == OP_REM) && (opa == OVF_QUO) && (opb == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = op[1] ? opa : DIV_ZERO_QUO;
    else          special_val = op[1] ? '0 : OVF_QUO;

    prod    = (s1 ^ s2) ? -acc : acc;
    quo_fix = (s1 ^ s2) ? -quo : quo;
    rem_fix = s1 ? -rem[31:0] : rem[31:0];
    if (op_is_div(op)) fix_val = op[1] ? rem_fix : quo_fix;
    else               fix_val = (op == OP_MUL) ? prod[31:0] : prod[63:32];
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_PREP;
      S_PREP:  state_next = special ? S_DONE : S_RUN;
      S_RUN:   if (cnt == 5'd31) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = start ? S_PREP : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush && state != S_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      acc    <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state_next == S_PREP) begin
            op  <= md_op;
            opa <= data1;
            opb <= data2;
          end
        end
        S_PREP: begin
          s1  <= sgn1;
          s2  <= sgn2;
          if (sgn1) opa <= -opa;
          if (sgn2) opb <= -opb;
          acc <= '0;
          rem <= '0;
          quo <= '0;
          cnt <= '0;
          if (state_next == S_DONE) result <= special_val;
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (op_is_div(op)) begin
            rem <= rem_step;
            quo <= {quo[30:0], q_bit};
          end else begin
            acc <= acc_step;
          end
        end
        S_FIX: begin
          if (state_next == S_DONE) result <= fix_val;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic reference model with a
// per-cycle busy/done/result comparison, plus literal expectations.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = '0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .data1  (data1),
    .data2  (data2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = '0;
    r = '0;
    case (op)
      OP_MUL:    begin p = longint'($signed(a)) * longint'($signed(b)); r = p[31:0]; end
      OP_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
      OP_MULHSU: begin p = longint'($signed(a)) * longint'({32'd0, b}); r = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      OP_DIV:    if (b == 0) r = 32'hFFFF_FFFF;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                 else r = $signed(a) / $signed(b);
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    if (b == 0) r = a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                 else r = $signed(a) % $signed(b);
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference timeline: an op occupies edges 0..lat, busy before lat, done at lat.
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          was_done;
  int          m_k = 0;
  int          m_lat = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      m_lat    = 0;
      m_pend   = '0;
      m_result = '0;
    end else begin
      was_done = m_done;
      m_done   = 1'b0;
      if (flush && (m_active || was_done)) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_k++;
        if (m_k == m_lat) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          m_result = m_pend;
        end
      end else if (start) begin
        m_active = 1'b1;
        m_k      = 0;
        m_lat    = is_special(md_op, data1, data2) ? 1 : 34;
        m_pend   = ref_result(md_op, data1, data2);
      end
    end
  end

  always @(negedge clk) begin
    tests++;
    if (busy !== m_active || done !== m_done || result !== m_result) begin
      fails++;
      $display("FAIL cycle_check t=%0t busy=%b want %b done=%b want %b result=%h want %h",
               $time, busy, m_active, done, m_done, result, m_result);
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Launch an op; optionally pulse a junk start at cycle 'poke' while busy.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int poke, input bit b2b);
    int n;
    int bc;
    if (!b2b) @(negedge clk);
    start = 1'b1;
    md_op = op;
    data1 = a;
    data2 = b;
    @(negedge clk);
    start = 1'b0;
    n  = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (n == poke) begin
        start = 1'b1;
        md_op = OP_MUL;
        data1 = 32'd3;
        data2 = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check32({name, "_model"}, ref_result(op, a, b), exp);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout no done within 40 cycles", name);
    end else begin
      check32({name, "_result"}, result, exp);
      check32({name, "_latency"}, n, exp_lat);
      check32({name, "_busy_cycles"}, bc, exp_lat);
    end
  endtask

  initial begin
    int n;
    int done_seen;
    @(negedge clk);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul_7_m3",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, -1, 1'b0);
    run_op("mulhu_ff",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, -1, 1'b0);
    run_op("mulh_ff",     OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, -1, 1'b0);
    run_op("mulhsu_ff",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, -1, 1'b0);
    run_op("div_m7_2",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, -1, 1'b0);
    run_op("rem_m7_2",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, -1, 1'b0);
    run_op("divu_7_2",    OP_DIVU,   32'd7,          32'd2,         32'd3,         34, 5,  1'b0);
    run_op("remu_7_2",    OP_REMU,   32'd7,          32'd2,         32'd1,         34, 20, 1'b0);
    run_op("div_5_0",     OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  -1, 1'b0);
    run_op("remu_5_0",    OP_REMU,   32'd5,          32'd0,         32'd5,         1,  -1, 1'b0);
    run_op("div_ovf",     OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  -1, 1'b0);
    run_op("rem_ovf",     OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  -1, 1'b0);

    // back-to-back: second start is raised in the first op's done cycle
    run_op("b2b_first",   OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, -1, 1'b0);
    run_op("b2b_second",  OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, -1, 1'b1);

    // flush raised after edge 10, sampled at edge 11
    @(negedge clk);
    start = 1'b1;
    md_op = OP_MULHU;
    data1 = 32'h1234_5678;
    data2 = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check32("flush_busy", {31'd0, busy}, 32'd0);
    check32("flush_result_kept", result, 32'hFFFF_FFFD);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check32("flush_no_done", done_seen, 32'd0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1;
    md_op = OP_MUL;
    data1 = 32'h0000_1234;
    data2 = 32'h0000_0010;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 15) begin
      @(negedge clk);
      n++;
    end
    check32("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("async_reset_busy", {31'd0, busy}, 32'd0);
    check32("async_reset_done", {31'd0, done}, 32'd0);
    check32("async_reset_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul_3_4",     OP_MUL,    32'd3,          32'd4,         32'd12,        34, -1, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
